// File: rtl/bus_pkg.sv
// Shared bus definitions for the DMA initiator: widths, state encoding
// and register-block offsets used by the CPU-side configuration logic.
package bus_pkg;

    localparam int BUS_AW = 20;
    localparam int BUS_DW = 16;
    localparam int DMA_LW = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_WAIT = 3'd4;
    localparam logic [2:0] ST_FINISH  = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        RD_REQ  = ST_RD_REQ,
        RD_WAIT = ST_RD_WAIT,
        WR_REQ  = ST_WR_REQ,
        WR_WAIT = ST_WR_WAIT,
        FINISH  = ST_FINISH
    } dma_state_e;

    // Word offsets of the DMA register block as seen by the CPU.
    localparam logic [3:0] DMA_REG_CTRL   = 4'h0;
    localparam logic [3:0] DMA_REG_STATUS = 4'h1;
    localparam logic [3:0] DMA_REG_SRC_LO = 4'h2;
    localparam logic [3:0] DMA_REG_SRC_HI = 4'h3;
    localparam logic [3:0] DMA_REG_DST_LO = 4'h4;
    localparam logic [3:0] DMA_REG_DST_HI = 4'h5;
    localparam logic [3:0] DMA_REG_LEN    = 4'h6;

endpackage

// File: rtl/bus_req_ctl.sv
// Single-access handshake engine: raises a read or write request level,
// holds it through target stalls and reports the accepting cycle.
module bus_req_ctl
    import bus_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic launch_i,
    input  logic write_i,
    input  logic ram_busy_i,
    input  logic ram_ready_i,
    output logic rd_o,
    output logic wr_o,
    output logic accept_o,
    output logic rd_done_o
);

    logic req_q, req_d;
    logic write_q, write_d;
    logic rd_done_q, rd_done_d;

    assign accept_o  = req_q && ram_ready_i && !ram_busy_i;
    assign rd_o      = req_q && !write_q;
    assign wr_o      = req_q && write_q;
    assign rd_done_o = rd_done_q;

    // Once raised, a request is only dropped by the target accepting it.
    always_comb begin
        req_d     = req_q;
        write_d   = write_q;
        rd_done_d = accept_o && !write_q;
        if (accept_o) begin
            req_d = 1'b0;
        end else if (launch_i && !req_q) begin
            req_d   = 1'b1;
            write_d = write_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q     <= 1'b0;
            write_q   <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            req_q     <= req_d;
            write_q   <= write_d;
            rd_done_q <= rd_done_d;
        end
    end

endmodule

// File: rtl/bus_dma_master.sv
// Block-copy bus initiator sharing the CPU memory handshake.
// Define DMA_FILL_EN to add fill_mode/fill_value (pattern fill, no reads).
module bus_dma_master
    import bus_pkg::*;
#(
    parameter int AW = BUS_AW,
    parameter int DW = BUS_DW,
    parameter int LW = DMA_LW
) (
    input  logic          cpu_clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
`ifdef DMA_FILL_EN
    input  logic          fill_mode,
    input  logic [DW-1:0] fill_value,
`endif
    input  logic          abort,
    input  logic          grant,
    output logic          dma_busy,
    output logic          done,
    output logic          aborted,
    output logic [AW-1:0] addr_bus,
    output logic [DW-1:0] ram_out,
    input  logic [DW-1:0] ram_in,
    output logic          ram_read,
    output logic          ram_write,
    output logic          ram_read_done,
    input  logic          ram_busy,
    input  logic          ram_ready
);

    dma_state_e    state_q;
    logic [AW-1:0] cur_src_q, cur_dst_q, addr_q;
    logic [LW-1:0] remain_q;
    logic [DW-1:0] data_q, wdata_q;
    logic          busy_q, done_q, aborted_q, abort_pend_q;
    logic          launch, launch_wr, accept;
    logic          fill_q, fill_start;
    logic [DW-1:0] fill_word;

`ifdef DMA_FILL_EN
    assign fill_start = fill_mode;
    assign fill_word  = fill_value;

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            fill_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            fill_q <= fill_mode;
        end
    end
`else
    assign fill_start = 1'b0;
    assign fill_word  = '0;
    assign fill_q     = 1'b0;
`endif

    assign launch    = grant && (state_q == RD_REQ || state_q == WR_REQ);
    assign launch_wr = (state_q == WR_REQ);

    bus_req_ctl u_req (
        .clk_i       (cpu_clk),
        .rst_i       (rst),
        .launch_i    (launch),
        .write_i     (launch_wr),
        .ram_busy_i  (ram_busy),
        .ram_ready_i (ram_ready),
        .rd_o        (ram_read),
        .wr_o        (ram_write),
        .accept_o    (accept),
        .rd_done_o   (ram_read_done)
    );

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_src_q    <= '0;
            cur_dst_q    <= '0;
            addr_q       <= '0;
            remain_q     <= '0;
            data_q       <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && abort) begin
                abort_pend_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        aborted_q    <= 1'b0;
                        abort_pend_q <= 1'b0;
                        cur_src_q    <= src;
                        cur_dst_q    <= dst;
                        remain_q     <= len;
                        if (fill_start) begin
                            data_q <= fill_word;
                        end
                        if (len == '0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= fill_start ? WR_REQ : RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (grant) begin
                        addr_q  <= cur_src_q;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (accept) begin
                        data_q  <= ram_in;
                        state_q <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (grant) begin
                        addr_q  <= cur_dst_q;
                        wdata_q <= data_q;
                        state_q <= WR_WAIT;
                    end
                end
                // A pending abort only takes effect once the word's write lands.
                WR_WAIT: begin
                    if (accept) begin
                        cur_src_q <= cur_src_q + AW'(1);
                        cur_dst_q <= cur_dst_q + AW'(1);
                        remain_q  <= remain_q - LW'(1);
                        if (remain_q == LW'(1) || abort_pend_q || abort) begin
                            state_q   <= FINISH;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            aborted_q <= (abort_pend_q || abort) && (remain_q != LW'(1));
                        end else begin
                            state_q <= fill_q ? WR_REQ : RD_REQ;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dma_busy = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign addr_bus = addr_q;
    assign ram_out  = wdata_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Scoreboard bench for bus_dma_master: a stalling memory target, expected
// bus traffic derived from src/dst/len arithmetic, and a done/latency model.
module tb_bus_dma_master;

    localparam int AW = bus_pkg::BUS_AW;
    localparam int DW = bus_pkg::BUS_DW;
    localparam int LW = bus_pkg::DMA_LW;

    typedef struct {
        int startCnt;
        int latency;
        bit abortedExp;
        int reads;
        int rdBase;
    } done_t;

    logic          cpu_clk = 1'b0;
    logic          rst, start, abort, grant;
    logic [AW-1:0] src, dst, addr_bus;
    logic [LW-1:0] len;
    logic [DW-1:0] ram_out, ram_in;
    logic          dma_busy, done, aborted, ram_read, ram_write, ram_read_done;
    logic          ram_busy, ram_ready;
`ifdef DMA_FILL_EN
    logic          fill_mode;
    logic [DW-1:0] fill_value;
`endif

    done_t         expDone[$];
    logic [AW-1:0] expRdAddr[$];
    logic [AW-1:0] expWrAddr[$];
    logic [DW-1:0] expWrData[$];
    logic [DW-1:0] mem[int];

    int            errors = 0;
    int            checks = 0;
    int            cycleCnt = 0;
    int            doneSeen = 0;
    int            readDoneCnt = 0;
    int            curStall = 0;
    int            stallCnt = 0;
    logic [AW-1:0] holdAddr;
    logic          holdRd;
    done_t         monRec;

    bus_dma_master dut (
        .cpu_clk       (cpu_clk),
        .rst           (rst),
        .start         (start),
        .src           (src),
        .dst           (dst),
        .len           (len),
`ifdef DMA_FILL_EN
        .fill_mode     (fill_mode),
        .fill_value    (fill_value),
`endif
        .abort         (abort),
        .grant         (grant),
        .dma_busy      (dma_busy),
        .done          (done),
        .aborted       (aborted),
        .addr_bus      (addr_bus),
        .ram_out       (ram_out),
        .ram_in        (ram_in),
        .ram_read      (ram_read),
        .ram_write     (ram_write),
        .ram_read_done (ram_read_done),
        .ram_busy      (ram_busy),
        .ram_ready     (ram_ready)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) cycleCnt++;

    // Unwritten locations read back as an address-derived pattern.
    function automatic logic [DW-1:0] memRd(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[15:0] ^ 16'h5A3C;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory target plus monitor: drives busy/ready, pops expectations on acceptance.
    always @(negedge cpu_clk) begin
        if (rst) begin
            ram_busy  = 1'b0;
            ram_ready = 1'b0;
            stallCnt  = 0;
            ram_in    = '0;
        end else begin
            if (ram_read_done) readDoneCnt++;
            if (ram_read && ram_write) checkOutput("readWriteExclusive", {30'd0, ram_read, ram_write}, 32'd2);
            if (ram_read || ram_write) begin
                if (stallCnt > 0) begin
                    checkOutput("stallAddrStable", 32'(addr_bus), 32'(holdAddr));
                    checkOutput("stallReqStable", 32'(ram_read), 32'(holdRd));
                end else begin
                    holdAddr = addr_bus;
                    holdRd   = ram_read;
                end
                if (stallCnt < curStall) begin
                    ram_busy  = 1'b1;
                    ram_ready = 1'b0;
                    ram_in    = DW'($urandom);
                    stallCnt++;
                end else begin
                    ram_busy  = 1'b0;
                    ram_ready = 1'b1;
                    stallCnt  = 0;
                    checkOutput("busyDuringAccess", 32'(dma_busy), 32'd1);
                    if (ram_read) begin
                        if (expRdAddr.size() == 0) checkOutput("unexpectedRead", 32'(ram_read), 32'd0);
                        else checkOutput("readAddr", 32'(addr_bus), 32'(expRdAddr.pop_front()));
                        ram_in = memRd(addr_bus);
                    end else begin
                        if (expWrAddr.size() == 0) checkOutput("unexpectedWrite", 32'(ram_write), 32'd0);
                        else begin
                            checkOutput("writeAddr", 32'(addr_bus), 32'(expWrAddr.pop_front()));
                            checkOutput("writeData", 32'(ram_out), 32'(expWrData.pop_front()));
                        end
                        mem[int'(addr_bus)] = ram_out;
                    end
                end
            end else begin
                ram_busy  = 1'b0;
                ram_ready = 1'b0;
                stallCnt  = 0;
                ram_in    = DW'($urandom);
            end
            if (done) begin
                if (expDone.size() == 0) checkOutput("unexpectedDone", 32'(done), 32'd0);
                else begin
                    monRec = expDone.pop_front();
                    checkOutput("doneLatency", 32'(cycleCnt - monRec.startCnt), 32'(monRec.latency));
                    checkOutput("abortedFlag", 32'(aborted), 32'(monRec.abortedExp));
                    checkOutput("readDoneCount", 32'(readDoneCnt - monRec.rdBase), 32'(monRec.reads));
                    checkOutput("writesOutstanding", 32'(expWrAddr.size()), 32'd0);
                end
                doneSeen++;
            end
        end
    end

    // One transfer: expected traffic comes from address arithmetic and the word
    // count; latency is per-word cost times words plus any grant delay.
    task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                                 input int stall, input int abortWord, input bit fillMode,
                                 input logic [DW-1:0] fv, input int grantDelay,
                                 input bit extraStart, input bit abortAtStart);
        int    words, prevDone;
        bit    found;
        done_t rec;
        logic [AW-1:0] a;
        words = (abortWord >= 0 && abortWord < n) ? abortWord + 1 : n;
        curStall = stall;
        for (int i = 0; i < words; i++) begin
            a = s + AW'(i);
            if (!fillMode) expRdAddr.push_back(a);
            expWrAddr.push_back(d + AW'(i));
            expWrData.push_back(fillMode ? fv : memRd(a));
        end
        rec.latency    = (words == 0) ? 0 : words * (fillMode ? 2 + stall : 4 + 2 * stall) + grantDelay;
        rec.abortedExp = (words < n);
        rec.reads      = fillMode ? 0 : words;
        prevDone = doneSeen;
        @(posedge cpu_clk); #1;
        src   = s;
        dst   = d;
        len   = LW'(n);
        start = 1'b1;
        abort = abortAtStart;
        grant = (grantDelay == 0);
`ifdef DMA_FILL_EN
        fill_mode  = fillMode;
        fill_value = fv;
`endif
        rec.startCnt = cycleCnt + 1;
        rec.rdBase   = readDoneCnt;
        expDone.push_back(rec);
        @(posedge cpu_clk); #1;
        start = 1'b0;
        abort = 1'b0;
        src   = AW'($urandom);
        len   = LW'($urandom_range(1, 9));
        checkOutput("abortedClearedOnStart", 32'(aborted), 32'd0);
        if (grantDelay > 0) begin
            repeat (grantDelay) @(posedge cpu_clk);
            #1 grant = 1'b1;
        end
        if (extraStart && n >= 2) begin
            @(posedge cpu_clk); #1 start = 1'b1;
            @(posedge cpu_clk); #1 start = 1'b0;
        end
        if (words < n) begin
            found = 1'b0;
            for (int c = 0; c < 500 && !found; c++) begin
                if (ram_read && addr_bus == s + AW'(abortWord)) found = 1'b1;
                else begin @(posedge cpu_clk); #1; end
            end
            checkOutput("abortWindowSeen", 32'(found), 32'd1);
            abort = 1'b1;
            @(posedge cpu_clk); #1 abort = 1'b0;
        end
        for (int c = 0; c < 3000 && doneSeen == prevDone; c++) @(posedge cpu_clk);
        checkOutput("doneArrived", 32'(doneSeen - prevDone), 32'd1);
        @(posedge cpu_clk); #1;
        checkOutput("idleAfterDone", 32'({dma_busy, ram_read, ram_write}), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] rs;
        bit            found;
        rst = 1'b1; start = 1'b0; abort = 1'b0; grant = 1'b1;
        src = '0; dst = '0; len = '0;
`ifdef DMA_FILL_EN
        fill_mode = 1'b0; fill_value = '0;
`endif
        repeat (3) @(posedge cpu_clk);
        #1;
        checkOutput("resetBusy", 32'(dma_busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetAborted", 32'(aborted), 32'd0);
        checkOutput("resetAddr", 32'(addr_bus), 32'd0);
        checkOutput("resetRamOut", 32'(ram_out), 32'd0);
        checkOutput("resetRead", 32'(ram_read), 32'd0);
        checkOutput("resetWrite", 32'(ram_write), 32'd0);
        checkOutput("resetReadDone", 32'(ram_read_done), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) mem[32'h20000 + i] = DW'(16'h1111 * (i + 1));
        applyStimulus(20'h20000, 20'h30000, 4, 0, -1, 1'b0, '0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            checkOutput("copiedWord", 32'(memRd(20'h30000 + AW'(i))), 32'(16'h1111 * (i + 1)));

        applyStimulus(20'h21000, 20'h31000, 3, 3, -1, 1'b0, '0, 0, 1'b0, 1'b0);
        applyStimulus(20'h22000, 20'h32000, 0, 0, -1, 1'b0, '0, 0, 1'b0, 1'b0);
        applyStimulus(20'hFFFFE, 20'h7FFFF, 3, 1, -1, 1'b0, '0, 0, 1'b0, 1'b0);
        applyStimulus(20'h23000, 20'h33000, 8, 0, 2, 1'b0, '0, 0, 1'b0, 1'b0);
        applyStimulus(20'h24000, 20'h34000, 2, 0, -1, 1'b0, '0, 0, 1'b0, 1'b1);
        applyStimulus(20'h25000, 20'h35000, 3, 0, -1, 1'b0, '0, 3, 1'b1, 1'b0);

        // Reset while a write is stalled: request drops, no done, queues discarded.
        curStall = 3;
        for (int i = 0; i < 5; i++) begin
            expRdAddr.push_back(20'h26000 + AW'(i));
            expWrAddr.push_back(20'h36000 + AW'(i));
            expWrData.push_back(memRd(20'h26000 + AW'(i)));
        end
        @(posedge cpu_clk); #1;
        src = 20'h26000; dst = 20'h36000; len = LW'(5); start = 1'b1;
        @(posedge cpu_clk); #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (ram_write) found = 1'b1;
            else begin @(posedge cpu_clk); #1; end
        end
        checkOutput("writeSeenBeforeReset", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge cpu_clk); #1;
        checkOutput("resetDropsWrite", 32'(ram_write), 32'd0);
        checkOutput("resetDropsRead", 32'(ram_read), 32'd0);
        checkOutput("resetNoDone", 32'(done), 32'd0);
        checkOutput("resetDropsBusy", 32'(dma_busy), 32'd0);
        rst = 1'b0;
        expRdAddr.delete(); expWrAddr.delete(); expWrData.delete(); expDone.delete();
        repeat (3) @(posedge cpu_clk);
        applyStimulus(20'h27000, 20'h37000, 4, 1, -1, 1'b0, '0, 0, 1'b0, 1'b0);

`ifdef DMA_FILL_EN
        applyStimulus(20'h28000, 20'h38000, 3, 0, -1, 1'b1, 16'hBEEF, 0, 1'b0, 1'b0);
        applyStimulus(20'h29000, 20'h39000, 4, 2, -1, 1'b1, 16'h1234, 0, 1'b0, 1'b0);
`endif

        for (int t = 0; t < 14; t++) begin
            rs = AW'($urandom);
            applyStimulus(rs, rs ^ 20'h80000, int'($urandom_range(0, 10)), int'($urandom_range(0, 2)),
                          -1, 1'b0, '0, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
